// File: rtl/camera_pkg.sv
// Shared definitions for the camera pixel-bus emulator and the colour path.
// Contents:
//   - RGB332 / RGB565 widths and a few reference RGB332 colours
//   - frame-sequencer state encoding
//   - line_clks(): byte clocks per line (active bytes plus blanking)
//   - cnt_width(): counter width for a 0..n-1 counter, never below one bit
package camera_pkg;

  localparam int RGB332_W = 8;
  localparam int RGB565_W = 16;

  localparam logic [RGB332_W-1:0] RGB332_RED   = 8'hE0;
  localparam logic [RGB332_W-1:0] RGB332_GREEN = 8'h1C;
  localparam logic [RGB332_W-1:0] RGB332_BLUE  = 8'h03;
  localparam logic [RGB332_W-1:0] RGB332_WHITE = 8'hFF;
  localparam logic [RGB332_W-1:0] RGB332_BLACK = 8'h00;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_VS     = 3'd1;
  localparam logic [2:0] ST_VBACK  = 3'd2;
  localparam logic [2:0] ST_ACTIVE = 3'd3;
  localparam logic [2:0] ST_VFRONT = 3'd4;

  // Each pixel goes out as two bytes, followed by the horizontal blank.
  function automatic int line_clks(input int h_active, input int h_blank);
    return 2 * h_active + h_blank;
  endfunction

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rgb332_to_rgb565.sv
// Combinational RGB332 -> RGB565 expander. Each channel is widened by
// replicating its top bits into the new low bits so full-scale stays
// full-scale (7 -> 31/63, 3 -> 31).
// Ports:
//   pix     in  8   RGB332 pixel {r[2:0], g[2:0], b[1:0]}
//   rgb565  out 16  RGB565 word {R5, G6, B5}
module rgb332_to_rgb565
  import camera_pkg::*;
(
  input  logic [RGB332_W-1:0] pix,
  output logic [RGB565_W-1:0] rgb565
);

  logic [2:0] r3;
  logic [2:0] g3;
  logic [1:0] b2;

  assign r3 = pix[7:5];
  assign g3 = pix[4:2];
  assign b2 = pix[1:0];

  assign rgb565 = {r3, r3[2:1], g3, g3, b2, b2, b2[1]};

endmodule

// File: rtl/camera_stream_tx.sv
// OV7670-style pixel bus source. Reads an RGB332 frame from a synchronous
// pixel RAM (one-cycle read latency), expands each pixel to RGB565 and emits
// it as two bytes, high byte first, framed by VSYNC and HREF.
//
// Frame: VS (VSYNC_LINES) -> VBACK (V_BACK) -> ACTIVE (V_ACTIVE) ->
// VFRONT (V_FRONT) -> one IDLE clock with FRAME_DONE -> VS again if EN.
// Every line is LINE_CLKS = 2*H_ACTIVE + H_BLANK clocks. All phase line
// counts must be >= 1 and H_BLANK >= 2 (pixel 0 is fetched inside the blank).
//
// Ports:
//   CLK         in   pixel clock, all outputs change on its rising edge
//   RST_N       in   asynchronous active-low reset
//   EN          in   frame request, sampled only in IDLE
//   RD_DATA     in   RGB332 pixel, valid one clock after RD_X/RD_Y
//   RD_X, RD_Y  out  registered RAM column / row address
//   DATA_OUT    out  byte bus, 0 whenever HREF is low
//   HREF        out  high for the 2*H_ACTIVE byte clocks of an active line
//   VSYNC       out  high during the vsync interval
//   BUSY        out  high from frame start to the last VFRONT clock
//   FRAME_DONE  out  one-clock pulse right after the last VFRONT clock
//   dbg_state   out  sequencer state (camera_pkg ST_* encoding)
//
// Read pipeline for pixel x of a line, counted in edges:
//   edge E-2 : address registered on RD_X/RD_Y
//   edge E-1 : RAM registers RD_DATA
//   edge E   : high byte driven from the expanded RD_DATA, word held
//   edge E+1 : low byte driven from the held word
module camera_stream_tx
  import camera_pkg::*;
#(
  parameter int H_ACTIVE    = 176,
  parameter int V_ACTIVE    = 144,
  parameter int H_BLANK     = 16,
  parameter int VSYNC_LINES = 3,
  parameter int V_BACK      = 17,
  parameter int V_FRONT     = 10
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic                EN,
  input  logic [RGB332_W-1:0] RD_DATA,
  output logic [14:0]         RD_X,
  output logic [14:0]         RD_Y,
  output logic [7:0]          DATA_OUT,
  output logic                HREF,
  output logic                VSYNC,
  output logic                BUSY,
  output logic                FRAME_DONE,
  output logic [2:0]          dbg_state
);

  localparam int LINE_CLKS = line_clks(H_ACTIVE, H_BLANK);
  localparam int MAX_LINES_A = (VSYNC_LINES > V_BACK) ? VSYNC_LINES : V_BACK;
  localparam int MAX_LINES_B = (V_ACTIVE > V_FRONT) ? V_ACTIVE : V_FRONT;
  localparam int MAX_LINES = (MAX_LINES_A > MAX_LINES_B) ? MAX_LINES_A : MAX_LINES_B;
  localparam int COL_W  = cnt_width(LINE_CLKS);
  localparam int LINE_W = cnt_width(MAX_LINES);

  logic [2:0]          state;
  logic [COL_W-1:0]    col_cnt;
  logic [LINE_W-1:0]   line_cnt;
  logic [RGB565_W-1:0] pix_word;

  logic [2:0]          nxt_state;
  logic [COL_W-1:0]    nxt_col;
  logic [LINE_W-1:0]   nxt_line;
  logic                done_set;
  logic [LINE_W-1:0]   last_line;
  logic [2:0]          phase_next;
  logic                line_end;

  logic [RGB565_W-1:0] rgb_word;
  logic                hi_slot;
  logic                lo_slot;
  logic                row0_issue;
  logic                next_pix_issue;

  rgb332_to_rgb565 u_expand (
    .pix    (RD_DATA),
    .rgb565 (rgb_word)
  );

  assign line_end = (col_cnt == COL_W'(LINE_CLKS - 1));

  // Length and successor of the phase currently being played.
  always_comb begin
    last_line  = LINE_W'(V_FRONT - 1);
    phase_next = ST_IDLE;
    case (state)
      ST_VS: begin
        last_line  = LINE_W'(VSYNC_LINES - 1);
        phase_next = ST_VBACK;
      end
      ST_VBACK: begin
        last_line  = LINE_W'(V_BACK - 1);
        phase_next = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        last_line  = LINE_W'(V_ACTIVE - 1);
        phase_next = ST_VFRONT;
      end
      default: begin
        last_line  = LINE_W'(V_FRONT - 1);
        phase_next = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    nxt_state = state;
    nxt_col   = col_cnt;
    nxt_line  = line_cnt;
    done_set  = 1'b0;
    if (state == ST_IDLE) begin
      nxt_col  = '0;
      nxt_line = '0;
      if (EN) nxt_state = ST_VS;
    end else if (state > ST_VFRONT) begin
      nxt_state = ST_IDLE;
      nxt_col   = '0;
      nxt_line  = '0;
    end else if (line_end) begin
      nxt_col = '0;
      if (line_cnt == last_line) begin
        nxt_line  = '0;
        nxt_state = phase_next;
        // Leaving VFRONT lands in IDLE for one clock, so FRAME_DONE can
        // never share an edge with the next VS entry.
        done_set  = (state == ST_VFRONT);
      end else begin
        nxt_line = line_cnt + LINE_W'(1);
      end
    end else begin
      nxt_col = col_cnt + COL_W'(1);
    end
  end

  // Byte slots and fetch slots are decoded from the values the counters
  // take on this edge, so the registered outputs line up with them.
  assign hi_slot = (nxt_state == ST_ACTIVE) && (nxt_col < COL_W'(2 * H_ACTIVE)) && !nxt_col[0];
  assign lo_slot = (nxt_state == ST_ACTIVE) && (nxt_col < COL_W'(2 * H_ACTIVE)) && nxt_col[0];

  // Pixel 0 of the coming active line is fetched two clocks before line end.
  assign row0_issue = (nxt_col == COL_W'(LINE_CLKS - 2)) &&
                      (((nxt_state == ST_VBACK) && (nxt_line == LINE_W'(V_BACK - 1))) ||
                       ((nxt_state == ST_ACTIVE) && (nxt_line < LINE_W'(V_ACTIVE - 1))));

  // Pixel x+1 is fetched on pixel x's high-byte edge; none after the last.
  assign next_pix_issue = hi_slot && (nxt_col < COL_W'(2 * H_ACTIVE - 2));

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state      <= ST_IDLE;
      col_cnt    <= '0;
      line_cnt   <= '0;
      pix_word   <= '0;
      DATA_OUT   <= '0;
      RD_X       <= '0;
      RD_Y       <= '0;
      FRAME_DONE <= 1'b0;
    end else begin
      state      <= nxt_state;
      col_cnt    <= nxt_col;
      line_cnt   <= nxt_line;
      FRAME_DONE <= done_set;

      if (hi_slot) begin
        DATA_OUT <= rgb_word[15:8];
        pix_word <= rgb_word;
      end else if (lo_slot) begin
        DATA_OUT <= pix_word[7:0];
      end else begin
        DATA_OUT <= '0;
      end

      if (row0_issue) begin
        RD_X <= '0;
        RD_Y <= (nxt_state == ST_VBACK) ? 15'd0 : 15'(nxt_line) + 15'd1;
      end else if (next_pix_issue) begin
        RD_X <= 15'(nxt_col[COL_W-1:1]) + 15'd1;
        RD_Y <= 15'(nxt_line);
      end
    end
  end

  assign VSYNC     = (state == ST_VS);
  assign BUSY      = (state != ST_IDLE);
  assign HREF      = (state == ST_ACTIVE) && (col_cnt < COL_W'(2 * H_ACTIVE));
  assign dbg_state = state;

endmodule

// File: tb/tb_camera_stream_tx.sv
// Bench for camera_stream_tx with a small frame (4x2 pixels, LINE_CLKS=11).
// A synchronous RAM model feeds RD_DATA; an expected per-clock frame
// waveform is built from hand-computed RGB565 words.
module tb_camera_stream_tx;

  localparam int H_ACTIVE    = 4;
  localparam int V_ACTIVE    = 2;
  localparam int H_BLANK     = 3;
  localparam int VSYNC_LINES = 1;
  localparam int V_BACK      = 1;
  localparam int V_FRONT     = 1;
  localparam int LC          = 2 * H_ACTIVE + H_BLANK;
  localparam int ACT_START   = VSYNC_LINES + V_BACK;
  localparam int FRAME_CLKS  = (VSYNC_LINES + V_BACK + V_ACTIVE + V_FRONT) * LC;

  typedef struct {
    logic [7:0]  pix;
    logic [15:0] word;
  } vec_t;

  logic        CLK;
  logic        RST_N;
  logic        EN;
  logic [7:0]  rd_data;
  logic [14:0] RD_X;
  logic [14:0] RD_Y;
  logic [7:0]  DATA_OUT;
  logic        HREF;
  logic        VSYNC;
  logic        BUSY;
  logic        FRAME_DONE;
  logic [2:0]  dbg_state;

  logic [7:0]  sa_pix;
  logic [15:0] sa_word;

  vec_t        vecs[0:8];
  logic [7:0]  ram[0:7];
  logic [29:0] addr_hist[0:FRAME_CLKS];

  int checks;
  int errors;

  camera_stream_tx #(
    .H_ACTIVE(H_ACTIVE), .V_ACTIVE(V_ACTIVE), .H_BLANK(H_BLANK),
    .VSYNC_LINES(VSYNC_LINES), .V_BACK(V_BACK), .V_FRONT(V_FRONT)
  ) dut (
    .CLK(CLK), .RST_N(RST_N), .EN(EN), .RD_DATA(rd_data),
    .RD_X(RD_X), .RD_Y(RD_Y), .DATA_OUT(DATA_OUT), .HREF(HREF),
    .VSYNC(VSYNC), .BUSY(BUSY), .FRAME_DONE(FRAME_DONE), .dbg_state(dbg_state)
  );

  rgb332_to_rgb565 u_sa (
    .pix(sa_pix),
    .rgb565(sa_word)
  );

  // clock / reset
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // synchronous pixel RAM, one-clock read latency
  always @(posedge CLK) begin
    rd_data <= ram[(int'(RD_Y) * H_ACTIVE + int'(RD_X)) % 8];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_data"},  32'(DATA_OUT), 32'd0);
    chk({tag, "_href"},  32'(HREF), 32'd0);
    chk({tag, "_vsync"}, 32'(VSYNC), 32'd0);
    chk({tag, "_busy"},  32'(BUSY), 32'd0);
    chk({tag, "_done"},  32'(FRAME_DONE), 32'd0);
    chk({tag, "_rdx"},   32'(RD_X), 32'd0);
    chk({tag, "_rdy"},   32'(RD_Y), 32'd0);
    chk({tag, "_state"}, 32'(dbg_state), 32'd0);
  endtask

  // Leaves the bench at the first negedge where VSYNC is seen high.
  task automatic wait_vsync(input int budget);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge CLK);
      if (VSYNC) begin
        seen = 1'b1;
        break;
      end
    end
    chk("vsync_timeout", 32'(seen), 32'd1);
  endtask

  // Checks clocks t=0..FRAME_CLKS of a frame, t=0 being the current negedge
  // (first VSYNC clock). EN takes en_after from t=1. abort_t >= 0 pulls
  // RST_N low just after that clock and checks the asynchronous clear.
  task automatic run_frame(input logic en_after, input int abort_t);
    int line, col, px, row;
    logic e_busy, e_vs, e_href, e_done;
    logic [7:0] e_data;
    logic [15:0] w;
    for (int t = 0; t <= FRAME_CLKS; t++) begin
      if (t > 0) @(negedge CLK);
      if (t == 1) EN = en_after;
      line = t / LC;
      col  = t % LC;
      e_busy = 1'b0; e_vs = 1'b0; e_href = 1'b0; e_done = 1'b0; e_data = 8'h00;
      if (t < FRAME_CLKS) begin
        e_busy = 1'b1;
        e_vs   = (line < VSYNC_LINES);
        e_href = (line >= ACT_START) && (line < ACT_START + V_ACTIVE) && (col < 2 * H_ACTIVE);
        if (e_href) begin
          row = line - ACT_START;
          px  = col / 2;
          w   = vecs[row * H_ACTIVE + px].word;
          e_data = (col % 2 == 0) ? w[15:8] : w[7:0];
        end
      end else begin
        e_done = 1'b1;
      end
      addr_hist[t] = {RD_Y, RD_X};
      chk("href",  32'(HREF), 32'(e_href));
      chk("vsync", 32'(VSYNC), 32'(e_vs));
      chk("busy",  32'(BUSY), 32'(e_busy));
      chk("frame_done", 32'(FRAME_DONE), 32'(e_done));
      chk("data_out", 32'(DATA_OUT), 32'(e_data));
      if (e_href && (col % 2 == 0)) begin
        chk("rd_addr_2_before_hi", 32'(addr_hist[t-2]), {2'b00, 15'(row), 15'(px)});
      end
      if (t == abort_t) begin
        #2 RST_N = 1'b0;
        #1 chk_all_zero("async_rst");
        return;
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    vecs[0] = '{8'hE0, 16'hF800};
    vecs[1] = '{8'h1C, 16'h07E0};
    vecs[2] = '{8'h03, 16'h001F};
    vecs[3] = '{8'hFF, 16'hFFFF};
    vecs[4] = '{8'h25, 16'h212A};
    vecs[5] = '{8'h92, 16'h9495};
    vecs[6] = '{8'h49, 16'h4A4A};
    vecs[7] = '{8'hB6, 16'hB5B5};
    vecs[8] = '{8'h00, 16'h0000};
    for (int i = 0; i < 8; i++) ram[i] = vecs[i].pix;

    // standalone expander, table-driven
    for (int i = 0; i < 9; i++) begin
      sa_pix = vecs[i].pix;
      #1;
      chk("expand", 32'(sa_word), 32'(vecs[i].word));
    end

    // reset state
    EN = 1'b0;
    RST_N = 1'b1;
    #1 RST_N = 1'b0;
    #2 chk_all_zero("reset");
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;
    @(negedge CLK);
    chk("idle_busy", 32'(BUSY), 32'd0);

    // single frame, EN dropped after start: back to idle
    EN = 1'b1;
    wait_vsync(4);
    run_frame(1'b0, -1);
    repeat (3) begin
      @(negedge CLK);
      chk("idle_after_vsync", 32'(VSYNC), 32'd0);
      chk("idle_after_busy",  32'(BUSY), 32'd0);
      chk("idle_after_done",  32'(FRAME_DONE), 32'd0);
    end

    // back-to-back frames: VSYNC rises on the clock after FRAME_DONE
    EN = 1'b1;
    wait_vsync(4);
    run_frame(1'b1, -1);
    @(negedge CLK);
    chk("b2b_vsync", 32'(VSYNC), 32'd1);
    chk("b2b_done_cleared", 32'(FRAME_DONE), 32'd0);
    run_frame(1'b0, -1);
    @(negedge CLK);
    chk("b2b_end_idle", 32'(BUSY), 32'd0);

    // reset during ACTIVE line 0, col 5, then a clean frame
    EN = 1'b1;
    wait_vsync(4);
    run_frame(1'b1, ACT_START * LC + 5);
    @(negedge CLK);
    chk_all_zero("held_rst");
    RST_N = 1'b1;
    wait_vsync(3);
    run_frame(1'b0, -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // global time bound
  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
